// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO between a producer and serial_alu
// Optional same-cycle bypass when empty: define ALU_CMD_FIFO_PASSTHRU_EN.
module alu_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_di1,
  input  logic [7:0]               in_di2,
  input  logic [1:0]               in_fun,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic [7:0]               out_di1,
  output logic [7:0]               out_di2,
  output logic [1:0]               out_fun,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0] mem_di1 [DEPTH];
  logic [7:0] mem_di2 [DEPTH];
  logic [1:0] mem_fun [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          stored_vld;
  logic          pt_hit;
  logic          push;
  logic          pop;

  // Readiness is derived from level only, never from out_rdy.
  always_comb begin
    in_rdy     = reset && (level != FULL_LVL);
    stored_vld = reset && (level != '0);
`ifdef ALU_CMD_FIFO_PASSTHRU_EN
    pt_hit     = reset && (level == '0) && in_vld && out_rdy;
`else
    pt_hit     = 1'b0;
`endif
    push       = in_vld && in_rdy && !pt_hit;
    pop        = stored_vld && out_rdy;
  end

  always_comb begin
    out_vld = stored_vld;
    out_di1 = mem_di1[rd_ptr];
    out_di2 = mem_di2[rd_ptr];
    out_fun = mem_fun[rd_ptr];
`ifdef ALU_CMD_FIFO_PASSTHRU_EN
    if (pt_hit) begin
      out_vld = 1'b1;
      out_di1 = in_di1;
      out_di2 = in_di2;
      out_fun = in_fun;
    end
`endif
  end

  // Storage is intentionally left unreset; out_* data is don't-care while empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_di1[wr_ptr] <= in_di1;
      mem_di2[wr_ptr] <= in_di2;
      mem_fun[wr_ptr] <= in_fun;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule
